// File: rtl/mips_sopc_top.sv
// Minimal MIPS32-subset system: single-cycle core (logic/shift/move/HI-LO ops)
// fetching from a word-addressed, bench-preloaded instruction ROM.
`timescale 1ns/1ps

module inst_rom #(
    parameter int ROM_DEPTH = 64
) (
    input  logic [29:0] addr,
    output logic [31:0] inst
);
    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic [31:0] memory [0:ROM_DEPTH-1];
    logic [AW-1:0] idx;

    assign idx = addr[AW-1:0];

    // Words beyond the array fetch as nop rather than aliasing low addresses.
    always_comb begin
        inst = 32'h0;
        if ({2'b00, addr} < 32'(ROM_DEPTH))
            inst = memory[idx];
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'h0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];
endmodule

module openmips #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    output logic [29:0] rom_addr
);
    logic [31:0] pc;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic signed [31:0] rt_sgn;

    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        hi_we;
    logic        lo_we;

    assign op       = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign sa       = inst[10:6];
    assign fn       = inst[5:0];
    assign imm      = inst[15:0];
    assign rt_sgn   = rt_val;
    assign rom_addr = pc[31:2];

    regfile regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (gpr_we),
        .waddr  (gpr_waddr),
        .wdata  (gpr_wdata),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val)
    );

    // Unknown or unlisted encodings fall to the defaults: no write anywhere.
    always_comb begin
        gpr_we    = 1'b0;
        gpr_waddr = rd;
        gpr_wdata = 32'h0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (op)
            6'h0D: begin gpr_we = 1'b1; gpr_waddr = rt; gpr_wdata = rs_val | {16'h0, imm}; end
            6'h0C: begin gpr_we = 1'b1; gpr_waddr = rt; gpr_wdata = rs_val & {16'h0, imm}; end
            6'h0E: begin gpr_we = 1'b1; gpr_waddr = rt; gpr_wdata = rs_val ^ {16'h0, imm}; end
            6'h0F: begin gpr_we = 1'b1; gpr_waddr = rt; gpr_wdata = {imm, 16'h0}; end
            6'h00: begin
                case (fn)
                    6'h24: begin gpr_we = 1'b1; gpr_wdata = rs_val & rt_val; end
                    6'h25: begin gpr_we = 1'b1; gpr_wdata = rs_val | rt_val; end
                    6'h26: begin gpr_we = 1'b1; gpr_wdata = rs_val ^ rt_val; end
                    6'h27: begin gpr_we = 1'b1; gpr_wdata = ~(rs_val | rt_val); end
                    6'h00: begin gpr_we = 1'b1; gpr_wdata = rt_val << sa; end
                    6'h02: begin gpr_we = 1'b1; gpr_wdata = rt_val >> sa; end
                    6'h03: begin gpr_we = 1'b1; gpr_wdata = rt_sgn >>> sa; end
                    6'h04: begin gpr_we = 1'b1; gpr_wdata = rt_val << rs_val[4:0]; end
                    6'h06: begin gpr_we = 1'b1; gpr_wdata = rt_val >> rs_val[4:0]; end
                    6'h07: begin gpr_we = 1'b1; gpr_wdata = rt_sgn >>> rs_val[4:0]; end
                    6'h0A: begin gpr_we = (rt_val == 32'h0); gpr_wdata = rs_val; end
                    6'h0B: begin gpr_we = (rt_val != 32'h0); gpr_wdata = rs_val; end
                    6'h10: begin gpr_we = 1'b1; gpr_wdata = hi; end
                    6'h12: begin gpr_we = 1'b1; gpr_wdata = lo; end
                    6'h11: hi_we = 1'b1;
                    6'h13: lo_we = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
            hi <= 32'h0;
            lo <= 32'h0;
        end else begin
            pc <= pc + 32'd4;
            if (hi_we)
                hi <= rs_val;
            if (lo_we)
                lo <= rs_val;
        end
    end
endmodule

module mips_sopc_top #(
    parameter int          ROM_DEPTH = 64,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    logic [29:0] rom_addr;
    logic [31:0] inst;

    openmips #(.RESET_PC(RESET_PC)) openmips (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .rom_addr (rom_addr)
    );

    inst_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
        .addr (rom_addr),
        .inst (inst)
    );
endmodule

// File: tb/tb_mips_sopc_top.sv
// Bench for mips_sopc_top: preloads a program into the ROM and checks the
// architectural effect of each instruction against a table of expectations.
`timescale 1ns/1ps

module tb_mips_sopc_top;
    logic clk;
    logic rst;

    mips_sopc_top dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = GPR idx, 1 = HI, 2 = LO
    typedef struct {
        logic [31:0] inst;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];
    vec_t sbq [$];

    int total = 0;
    int bad   = 0;

    logic [31:0] mreg [32];
    logic [31:0] mhi;
    logic [31:0] mlo;

    function automatic vec_t mk(logic [31:0] inst, int kind, int idx, logic [31:0] exp);
        vec_t v;
        v.inst = inst; v.kind = kind; v.idx = idx; v.exp = exp;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_cleared(string tag);
        chk({tag, " pc"}, dut.openmips.pc, 32'h0);
        chk({tag, " hi"}, dut.openmips.hi, 32'h0);
        chk({tag, " lo"}, dut.openmips.lo, 32'h0);
        for (int r = 0; r < 32; r++)
            chk($sformatf("%s reg%0d", tag, r), dut.openmips.regfile.regs[r], 32'h0);
    endtask

    initial begin
        vecs[0]  = mk(32'h3C010000, 0, 1,  32'h00000000); // lui $1,0
        vecs[1]  = mk(32'h3C02FFFF, 0, 2,  32'hffff0000); // lui $2,0xffff
        vecs[2]  = mk(32'h3C030505, 0, 3,  32'h05050000); // lui $3,0x0505
        vecs[3]  = mk(32'h0041200A, 0, 4,  32'hffff0000); // movz $4,$2,$1
        vecs[4]  = mk(32'h0061200B, 0, 4,  32'hffff0000); // movn $4,$3,$1
        vecs[5]  = mk(32'h0062200B, 0, 4,  32'h05050000); // movn $4,$3,$2
        vecs[6]  = mk(32'h0043200A, 0, 4,  32'h05050000); // movz $4,$2,$3
        vecs[7]  = mk(32'h00000011, 1, 0,  32'h00000000); // mthi $0
        vecs[8]  = mk(32'h00400011, 1, 0,  32'hffff0000); // mthi $2
        vecs[9]  = mk(32'h00600011, 1, 0,  32'h05050000); // mthi $3
        vecs[10] = mk(32'h00002010, 0, 4,  32'h05050000); // mfhi $4
        vecs[11] = mk(32'h00600013, 2, 0,  32'h05050000); // mtlo $3
        vecs[12] = mk(32'h00400013, 2, 0,  32'hffff0000); // mtlo $2
        vecs[13] = mk(32'h00200013, 2, 0,  32'h00000000); // mtlo $1
        vecs[14] = mk(32'h00002012, 0, 4,  32'h00000000); // mflo $4
        vecs[15] = mk(32'h34011100, 0, 1,  32'h00001100); // ori $1,$0,0x1100
        vecs[16] = mk(32'h34210020, 0, 1,  32'h00001120); // ori $1,$1,0x20
        vecs[17] = mk(32'h3822FFFF, 0, 2,  32'h0000eedf); // xori $2,$1,0xffff
        vecs[18] = mk(32'h00021900, 0, 3,  32'h000eedf0); // sll $3,$2,4
        vecs[19] = mk(32'h3400FFFF, 0, 0,  32'h00000000); // ori $0,$0,0xffff
        vecs[20] = mk(32'h30450FF0, 0, 5,  32'h00000ed0); // andi $5,$2,0x0ff0
        vecs[21] = mk(32'h00403027, 0, 6,  32'hffff1120); // nor $6,$2,$0
        vecs[22] = mk(32'h00063903, 0, 7,  32'hfffff112); // sra $7,$6,4
        vecs[23] = mk(32'h00064102, 0, 8,  32'h0ffff112); // srl $8,$6,4
        vecs[24] = mk(32'h340A0008, 0, 10, 32'h00000008); // ori $10,$0,8
        vecs[25] = mk(32'h01434804, 0, 9,  32'h0eedf000); // sllv $9,$3,$10
        vecs[26] = mk(32'h01465807, 0, 11, 32'hffffff11); // srav $11,$6,$10
        vecs[27] = mk(32'h01466006, 0, 12, 32'h00ffff11); // srlv $12,$6,$10
        vecs[28] = mk(32'h00456824, 0, 13, 32'h00000ed0); // and $13,$2,$5
        vecs[29] = mk(32'h00227025, 0, 14, 32'h0000ffff); // or $14,$1,$2
        vecs[30] = mk(32'h00627826, 0, 15, 32'h000e032f); // xor $15,$3,$2
        vecs[31] = mk(32'h00000000, 0, 15, 32'h000e032f); // nop
        vecs[32] = mk(32'h00227820, 0, 15, 32'h000e032f); // add: unsupported -> nop

        for (int i = 0; i < 64; i++)
            dut.rom.memory[i] = 32'h0;
        for (int i = 0; i < NV; i++)
            dut.rom.memory[i] = vecs[i].inst;
        for (int r = 0; r < 32; r++)
            mreg[r] = 32'h0;
        mhi = 32'h0;
        mlo = 32'h0;

        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_cleared("reset");

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vec_t e;
            sbq.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            case (e.kind)
                1: begin
                    chk($sformatf("step%0d hi", i), dut.openmips.hi, e.exp);
                    mhi = e.exp;
                end
                2: begin
                    chk($sformatf("step%0d lo", i), dut.openmips.lo, e.exp);
                    mlo = e.exp;
                end
                default: begin
                    chk($sformatf("step%0d reg%0d", i, e.idx),
                        dut.openmips.regfile.regs[e.idx], e.exp);
                    if (e.idx != 0)
                        mreg[e.idx] = e.exp;
                end
            endcase
        end

        // Run through the zero-filled tail and 10 words beyond the ROM end.
        repeat (41) @(posedge clk);
        #1;
        chk("pastrom pc", dut.openmips.pc, 32'd296);
        chk("pastrom hi", dut.openmips.hi, mhi);
        chk("pastrom lo", dut.openmips.lo, mlo);
        for (int r = 0; r < 32; r++)
            chk($sformatf("pastrom reg%0d", r), dut.openmips.regfile.regs[r], mreg[r]);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cleared("rerst1");

        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("run5 pc", dut.openmips.pc, 32'd20);
        chk("run5 reg2", dut.openmips.regfile.regs[2], 32'hffff0000);
        chk("run5 reg4", dut.openmips.regfile.regs[4], 32'hffff0000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cleared("rerst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
